// File: rtl/smg_source_arbiter.sv
// Round-robin selector that time-shares the 4-digit seven-segment display
// between up to four 16-bit debug sources, with auto dwell, manual step and freeze.
module smg_source_arbiter #(
    parameter logic [16:0] T1MS     = 17'd99999,
    parameter logic [15:0] DWELL_MS = 16'd2000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  Req,
    input  logic [15:0] Src0_Data,
    input  logic [15:0] Src1_Data,
    input  logic [15:0] Src2_Data,
    input  logic [15:0] Src3_Data,
    input  logic        Mode,
    input  logic        Step_Pulse,
    input  logic        Freeze,
    output logic [15:0] Number_Sig,
    output logic [1:0]  Src_Sel,
    output logic        Sel_Valid,
    output logic [3:0]  Src_LED
);

    localparam int unsigned MS_W   = 17;
    localparam int unsigned DW_W   = 16;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned NSRC   = 4;
    localparam int unsigned SEL_W  = 2;

    typedef enum logic {IDLE, SHOW} state_t;

    state_t              state, state_nxt;
    logic [MS_W-1:0]     ms_cnt;
    logic                tick_c;
    logic [DW_W-1:0]     dwell, dwell_nxt;
    logic                mode_q;
    logic [SEL_W-1:0]    sel_nxt;
    logic                valid_nxt;
    logic [NSRC-1:0]     led_nxt;
    logic [DATA_W-1:0]   number_nxt;
    logic [DATA_W-1:0]   src_data_c;
    logic                adv_c;
    logic                found_c;
    logic [SEL_W-1:0]    found_idx_c;
    logic [SEL_W-1:0]    lowest_c;

    // Free-running millisecond prescaler
    assign tick_c = (ms_cnt == T1MS);

    always_ff @(posedge CLK) begin
        if (RST) begin
            ms_cnt <= '0;
        end else if (tick_c) begin
            ms_cnt <= '0;
        end else begin
            ms_cnt <= ms_cnt + MS_W'(1);
        end
    end

    // Next requested source after the current one, in rotation order
    always_comb begin
        found_c     = 1'b0;
        found_idx_c = Src_Sel;
        for (int unsigned k = 1; k < NSRC; k++) begin
            if (!found_c && Req[Src_Sel + SEL_W'(k)]) begin
                found_c     = 1'b1;
                found_idx_c = Src_Sel + SEL_W'(k);
            end
        end
    end

    // Lowest requested index, used when leaving IDLE
    always_comb begin
        lowest_c = '0;
        for (int k = int'(NSRC) - 1; k >= 0; k--) begin
            if (Req[k]) begin
                lowest_c = SEL_W'(k);
            end
        end
    end

    always_comb begin
        case (Src_Sel)
            2'd0:    src_data_c = Src0_Data;
            2'd1:    src_data_c = Src1_Data;
            2'd2:    src_data_c = Src2_Data;
            default: src_data_c = Src3_Data;
        endcase
    end

    // State register and all registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            dwell      <= '0;
            mode_q     <= 1'b0;
            Src_Sel    <= '0;
            Sel_Valid  <= 1'b0;
            Src_LED    <= '0;
            Number_Sig <= '0;
        end else begin
            state      <= state_nxt;
            dwell      <= dwell_nxt;
            mode_q     <= Mode;
            Src_Sel    <= sel_nxt;
            Sel_Valid  <= valid_nxt;
            Src_LED    <= led_nxt;
            Number_Sig <= number_nxt;
        end
    end

    // Next-state, selection and dwell logic; a forced advance outranks step and auto
    always_comb begin
        state_nxt = state;
        sel_nxt   = Src_Sel;
        dwell_nxt = dwell;
        adv_c     = 1'b0;

        case (state)
            IDLE: begin
                if (Req != '0) begin
                    state_nxt = SHOW;
                    sel_nxt   = lowest_c;
                    dwell_nxt = '0;
                end
            end
            SHOW: begin
                adv_c = !Req[Src_Sel]
                     || (!Mode && Step_Pulse && !Freeze)
                     || (Mode && !Freeze && tick_c && (dwell == DWELL_MS - 16'd1));
                if (adv_c) begin
                    dwell_nxt = '0;
                    if (found_c) begin
                        sel_nxt = found_idx_c;
                    end else if (!Req[Src_Sel]) begin
                        state_nxt = IDLE;
                    end
                end else if (Mode != mode_q) begin
                    dwell_nxt = '0;
                end else if (Mode && !Freeze && tick_c) begin
                    dwell_nxt = dwell + DW_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        valid_nxt  = (state_nxt == SHOW);
        led_nxt    = valid_nxt ? (NSRC'(1) << sel_nxt) : '0;
        number_nxt = Freeze ? Number_Sig : (Sel_Valid ? src_data_c : '0);
    end

endmodule

// File: tb/tb_smg_source_arbiter.sv
// Directed bench for smg_source_arbiter with a 4-cycle ms tick and 2 ms dwell.
module tb_smg_source_arbiter;

    logic        CLK;
    logic        RST;
    logic [3:0]  Req;
    logic [15:0] Src0_Data, Src1_Data, Src2_Data, Src3_Data;
    logic        Mode, Step_Pulse, Freeze;
    logic [15:0] Number_Sig;
    logic [1:0]  Src_Sel;
    logic        Sel_Valid;
    logic [3:0]  Src_LED;

    int n_vec = 0;
    int n_err = 0;

    smg_source_arbiter #(
        .T1MS    (17'd3),
        .DWELL_MS(16'd2)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .Req       (Req),
        .Src0_Data (Src0_Data),
        .Src1_Data (Src1_Data),
        .Src2_Data (Src2_Data),
        .Src3_Data (Src3_Data),
        .Mode      (Mode),
        .Step_Pulse(Step_Pulse),
        .Freeze    (Freeze),
        .Number_Sig(Number_Sig),
        .Src_Sel   (Src_Sel),
        .Sel_Valid (Sel_Valid),
        .Src_LED   (Src_LED)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse();
        Step_Pulse = 1'b1;
        cyc(1);
        Step_Pulse = 1'b0;
    endtask

    initial begin
        int cnt;
        logic bad;

        RST = 1'b1; Req = 4'b0000; Mode = 1'b0; Step_Pulse = 1'b0; Freeze = 1'b0;
        Src0_Data = 16'h0001; Src1_Data = 16'h1234; Src2_Data = 16'h2222; Src3_Data = 16'hABCD;
        cyc(2);
        check("rst_sel",   16'(Src_Sel),   16'd0);
        check("rst_valid", 16'(Sel_Valid), 16'd0);
        check("rst_num",   Number_Sig,     16'h0000);
        check("rst_led",   16'(Src_LED),   16'h0000);

        // 1: auto rotation between sources 1 and 3
        RST = 1'b0; Req = 4'b1010; Mode = 1'b1;
        cyc(1);
        check("t1_entry_sel",   16'(Src_Sel),   16'd1);
        check("t1_entry_valid", 16'(Sel_Valid), 16'd1);
        check("t1_entry_led",   16'(Src_LED),   16'b0010);
        check("t1_entry_num",   Number_Sig,     16'h0000);
        cyc(1);
        check("t1_num_1234", Number_Sig, 16'h1234);
        cnt = 0;
        while (Src_Sel != 2'd3 && cnt < 20) begin
            cyc(1);
            cnt++;
        end
        check("t1_sel3", 16'(Src_Sel), 16'd3);
        check("t1_led3", 16'(Src_LED), 16'b1000);
        cyc(1);
        check("t1_num_abcd", Number_Sig, 16'hABCD);
        cnt = 1;
        while (Src_Sel == 2'd3 && cnt < 20) begin
            cyc(1);
            cnt++;
        end
        check("t1_dwell_cycles", 16'(cnt), 16'd8);
        check("t1_back_to_1",    16'(Src_Sel), 16'd1);
        check("t1_led1",         16'(Src_LED), 16'b0010);

        // 2: manual stepping
        RST = 1'b1; Req = 4'b1111; Mode = 1'b0;
        cyc(1);
        RST = 1'b0;
        cyc(1);
        check("t2_entry_sel", 16'(Src_Sel), 16'd0);
        pulse();
        check("t2_step1", 16'(Src_Sel), 16'd1);
        pulse();
        check("t2_step2", 16'(Src_Sel), 16'd2);
        pulse();
        check("t2_step3", 16'(Src_Sel), 16'd3);
        cyc(100);
        check("t2_hold", 16'(Src_Sel), 16'd3);
        Mode = 1'b1;
        pulse();
        check("t2_step_in_auto", 16'(Src_Sel), 16'd3);
        Mode = 1'b0;
        cyc(1);
        check("t2_num", Number_Sig, 16'hABCD);

        // 3: forced advance coinciding with a step pulse, then all requests dropped
        pulse(); pulse(); pulse();
        check("t3_sel2", 16'(Src_Sel), 16'd2);
        Req = 4'b1011;
        pulse();
        check("t3_forced_one_adv", 16'(Src_Sel), 16'd3);
        cyc(1);
        check("t3_num", Number_Sig, 16'hABCD);
        Req = 4'b0000;
        cyc(1);
        check("t3_idle_valid", 16'(Sel_Valid), 16'd0);
        check("t3_idle_led",   16'(Src_LED),   16'h0000);
        check("t3_idle_sel",   16'(Src_Sel),   16'd3);
        cyc(1);
        check("t3_idle_num", Number_Sig, 16'h0000);

        // 4: freeze holds the value and blocks auto advance
        Req = 4'b0011; Mode = 1'b1;
        cyc(2);
        check("t4_sel0", 16'(Src_Sel), 16'd0);
        check("t4_num1", Number_Sig,   16'h0001);
        Freeze = 1'b1; Src0_Data = 16'h0002;
        cyc(20);
        check("t4_frozen_num", Number_Sig,   16'h0001);
        check("t4_frozen_sel", 16'(Src_Sel), 16'd0);
        Freeze = 1'b0;
        cyc(1);
        check("t4_released_num", Number_Sig, 16'h0002);

        // 5: single requester stays selected across many dwell periods
        Req = 4'b0100;
        cyc(1);
        check("t5_sel2", 16'(Src_Sel), 16'd2);
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (Src_Sel != 2'd2 || !Sel_Valid || dut.dwell >= 16'd2) bad = 1'b1;
        end
        check("t5_stable", 16'(bad), 16'd0);

        // 6: reset mid-dwell while frozen
        Req = 4'b1000; Freeze = 1'b1;
        cyc(1);
        check("t6_forced_sel3", 16'(Src_Sel), 16'd3);
        cyc(5);
        RST = 1'b1;
        cyc(1);
        check("t6_rst_sel",   16'(Src_Sel),   16'd0);
        check("t6_rst_valid", 16'(Sel_Valid), 16'd0);
        check("t6_rst_num",   Number_Sig,     16'h0000);
        check("t6_rst_led",   16'(Src_LED),   16'h0000);
        RST = 1'b0;
        cyc(1);
        check("t6_reacq_sel",   16'(Src_Sel),   16'd3);
        check("t6_reacq_valid", 16'(Sel_Valid), 16'd1);
        check("t6_reacq_led",   16'(Src_LED),   16'b1000);
        Freeze = 1'b0;
        cyc(1);
        check("t6_num", Number_Sig, 16'hABCD);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/smg_source_arbiter.md
Name: smg_source_arbiter

Overview:
- Shares the single 4-digit seven-segment display between up to four 16-bit debug sources (e.g. PC, instruction, ALU result, memory data).
- Selects one source by round-robin, either auto-rotating on a millisecond dwell timer or stepping on a button pulse.
- Drives the 16-bit Number_Sig bus consumed by the digit-scan controller.
- Provides a freeze function and an indication of which source is on display.

Parameters:
- T1MS, 17'd99999: CLK cycles per 1 ms tick minus 1. The ms counter runs 0..T1MS.
- DWELL_MS, 16'd2000: ms ticks each source stays on display in auto mode. Legal range is 1 and above.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RST  in  1  synchronous, active-high reset.
- Req  in  4  per-source enable; bit k=1 means source k may be displayed.
- Src0_Data  in  16  source 0 value.
- Src1_Data  in  16  source 1 value.
- Src2_Data  in  16  source 2 value.
- Src3_Data  in  16  source 3 value.
- Mode  in  1  0 = manual step, 1 = auto rotate.
- Step_Pulse  in  1  single-cycle, pre-debounced advance request; honoured only when Mode=0.
- Freeze  in  1  1 = hold the displayed value and block normal advances.
- Number_Sig  out  16  registered value sent to the scan controller.
- Src_Sel  out  2  index of the current source.
- Sel_Valid  out  1  1 = a source is currently selected.
- Src_LED  out  4  one-hot of Src_Sel when Sel_Valid=1, otherwise 4'b0000.

Behaviour:

Reset (RST=1 at a rising edge):
- ms counter=0, dwell counter=0, state=IDLE.
- Src_Sel=0, Sel_Valid=0, Number_Sig=16'h0000, Src_LED=0.
- Reset takes precedence over every other input, including mid-dwell and mid-freeze.

Millisecond timer:
- C1 counts 0..T1MS and wraps.
- tick=1 in the cycle where C1==T1MS.
- C1 is free-running and is not reset by mode or selection changes.

IDLE state (Sel_Valid=0):
- If Req!=0, the next edge enters SHOW with Src_Sel = lowest set index of Req and Sel_Valid=1.
- If Req==0, the block stays in IDLE.

SHOW state, advance events in priority order:
1. Forced: Req[Src_Sel]==0. Ignores Freeze and Mode.
2. Step: Mode=0, Step_Pulse=1, Freeze=0.
3. Auto: Mode=1, Freeze=0, tick=1 and dwell==DWELL_MS-1.

Advance rule:
- Search indices Src_Sel+1, +2, +3 (mod 4) in that order; load the first with its Req bit set.
- If none is set but the current source is still requested (Req[Src_Sel]=1), Src_Sel is unchanged (single-source case).
- If no Req bit is set at all, go to IDLE: Sel_Valid=0, Src_Sel holds its old value.
- Every advance resets dwell to 0, even when Src_Sel is unchanged.

Dwell counter:
- Increments on each tick only in SHOW with Mode=1 and Freeze=0; otherwise it holds.
- Cleared on an advance, on any Mode change, and on entry to SHOW.

Number_Sig:
- Each cycle with Freeze=0: Number_Sig <= Sel_Valid ? SrcN_Data[Src_Sel] : 16'h0000.
- Latency is 1 cycle from a source-data change, and 1 cycle after an Src_Sel update.
- With Freeze=1, Number_Sig holds. A forced advance still updates Src_Sel and Src_LED, but Number_Sig keeps the old value until Freeze falls.

Src_LED:
- Registered alongside Src_Sel and Sel_Valid, so it changes on the same edge.

Boundary cases:
- Step_Pulse while Mode=1: ignored.
- Step_Pulse on the same cycle as a forced advance: one advance only.
- Req changes on the same cycle as an advance: the search uses the Req value sampled at that edge.

Test Plan (T1MS=3, DWELL_MS=2 unless noted):
1. Reset, then Req=4'b1010, Mode=1, Src1_Data=16'h1234, Src3_Data=16'hABCD.
   - Entry: SHOW with Src_Sel=1, Sel_Valid=1.
   - Number_Sig=16'h1234 one cycle after entry.
   - Src_Sel goes 1→3→1 with 8 cycles per dwell; Src_LED goes 0010→1000.
2. Mode=0, Req=4'b1111, Src_Sel=0; apply three Step_Pulses.
   - Src_Sel goes 1, 2, 3.
   - Holding Mode=0 for 100 cycles with no pulse: no change.
   - Step_Pulse with Mode=1: ignored.
3. Src_Sel=2, Req=4'b1111; clear Req[2].
   - Next edge: Src_Sel=3 (forced advance).
   - Clear all Req: Sel_Valid=0, Number_Sig=0, Src_LED=0.
4. Freeze=1 with Src0_Data changing 16'h0001→16'h0002.
   - Number_Sig holds 16'h0001; no auto-advance.
   - Release Freeze: Number_Sig=16'h0002 on the next cycle.
5. Req=4'b0100, Mode=1.
   - Src_Sel stays 2 across many dwell periods; dwell counter still clears each period.
6. Assert RST mid-dwell with Src_Sel=3 and Freeze=1.
   - All outputs return to reset values on the next edge.
   - Re-acquisition happens on the first edge after RST falls.
